// File: rtl/writeback_buffer.sv
// Purpose : small in-order write-back FIFO between a result producer and a
//           single register-file write port, with optional read forwarding.
// Latency : 1 cycle from acceptance to write strobe. Drains one entry per cycle.
// Backpr. : in_ready drops only when all DEPTH entries are occupied. stall
//           freezes the drain side, and the enqueue side keeps filling.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready        producer handshake; in_reg/in_data = offered result
//   stall                    register-file write port busy; no drain this cycle
//   write/wreg/wd            register-file write strobe, index and data (head entry)
//   rreg1/rreg2              read indices being issued this cycle
//   fwd1_hit/fwd1_data,
//   fwd2_hit/fwd2_data       youngest pending value for rreg1/rreg2 (0 when none)
//   count                    number of occupied entries
//
// Build option: define WB_BYPASS_EN to enable the forwarding search. Without
// it, the fwd* outputs are tied to zero and the search logic is not built.

module writeback_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_reg,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     stall,
  output logic                     write,
  output logic [2:0]               wreg,
  output logic [WIDTH-1:0]         wd,
  input  logic [2:0]               rreg1,
  input  logic [2:0]               rreg2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [WIDTH-1:0]         fwd1_data,
  output logic [WIDTH-1:0]         fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage. It is not reset, because occupancy is tracked by the pointers and count.
  logic [2:0]       r_reg_mem  [DEPTH];
  logic [WIDTH-1:0] r_data_mem [DEPTH];

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_ready;
  logic             w_write;
  logic             w_enq;
  logic             w_deq;

  // Handshake and drain strobes depend only on registered state and stall.
  // No path exists from the in_* inputs to write.
  assign w_ready = (r_count != CW'(DEPTH));
  assign w_write = (r_count != '0) && !stall;
  assign w_enq   = in_valid && w_ready;
  assign w_deq   = w_write;

  assign in_ready = w_ready;
  assign write    = w_write;
  assign wreg     = r_reg_mem[r_head];
  assign wd       = r_data_mem[r_head];
  assign count    = r_count;

  // Pointer and occupancy-count control. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_deq) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry write port. Writes occur only on accepted results.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_reg_mem[r_tail]  <= in_reg;
      r_data_mem[r_tail] <= in_data;
    end
  end

`ifdef WB_BYPASS_EN
  // Per-entry occupied flags let the search ignore stale slots without
  // doing a pointer-range compare on every entry.
  logic [DEPTH-1:0] r_occ;
  logic [AW-1:0]    w_idx;
  logic             w_hit1;
  logic             w_hit2;
  logic [WIDTH-1:0] w_dat1;
  logic [WIDTH-1:0] w_dat2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      // The head and tail can coincide on the same edge only when the buffer is empty
      // or full. In those cases only one of w_deq/w_enq is high, so the order here is safe.
      if (w_deq) begin
        r_occ[r_head] <= 1'b0;
      end
      if (w_enq) begin
        r_occ[r_tail] <= 1'b1;
      end
    end
  end

  // The loop walks from the oldest entry to the youngest, so a later match overrides an earlier one.
  // The head entry stays visible even when it drains this cycle. A result
  // offered on in_* this cycle is not yet stored, so the search never sees it.
  always_comb begin
    w_idx  = '0;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_dat1 = '0;
    w_dat2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + AW'(k);
      if (r_occ[w_idx] && (r_reg_mem[w_idx] == rreg1)) begin
        w_hit1 = 1'b1;
        w_dat1 = r_data_mem[w_idx];
      end
      if (r_occ[w_idx] && (r_reg_mem[w_idx] == rreg2)) begin
        w_hit2 = 1'b1;
        w_dat2 = r_data_mem[w_idx];
      end
    end
  end

  assign fwd1_hit  = w_hit1;
  assign fwd2_hit  = w_hit2;
  assign fwd1_data = w_dat1;
  assign fwd2_data = w_dat2;
`else
  // Forwarding is not built. The read indices are intentionally unused.
  logic w_unused_rd;
  assign w_unused_rd = ^{rreg1, rreg2};

  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
module tb_writeback_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_reg;
  logic [WIDTH-1:0]  in_data;
  logic              stall;
  logic              write;
  logic [2:0]        wreg;
  logic [WIDTH-1:0]  wd;
  logic [2:0]        rreg1;
  logic [2:0]        rreg2;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [WIDTH-1:0]  fwd1_data;
  logic [WIDTH-1:0]  fwd2_data;
  logic [2:0]        count;

  writeback_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .stall     (stall),
    .write     (write),
    .wreg      (wreg),
    .wd        (wd),
    .rreg1     (rreg1),
    .rreg2     (rreg2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The reference model is the ordered list of pending writes, oldest first.
  typedef struct {
    logic [2:0]       r;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the youngest pending value for a register. When no such value exists, it returns 0.
  task automatic model_fwd(input logic [2:0] rr, output logic hit, output logic [WIDTH-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_BYPASS_EN
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].r == rr) begin
        hit = 1'b1;
        d   = q[i].d;
        break;
      end
    end
`endif
  endtask

  task automatic check_outputs();
    logic              exp_wr;
    logic              h1, h2;
    logic [WIDTH-1:0]  d1, d2;
    exp_wr = (q.size() != 0) && !stall;
    chk("in_ready", in_ready, (q.size() != DEPTH));
    chk("count", count, q.size());
    chk("write", write, exp_wr);
    if (exp_wr && write) begin
      chk("wreg", wreg, q[0].r);
      chk("wd", wd, q[0].d);
    end
    model_fwd(rreg1, h1, d1);
    model_fwd(rreg2, h2, d2);
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd1_data", fwd1_data, d1);
    chk("fwd2_hit", fwd2_hit, h2);
    chk("fwd2_data", fwd2_data, d2);
  endtask

  // At each rising edge, the model pops the head if a write is issued and appends an accepted result.
  task automatic model_update();
    bit acc, deq;
    ent_t e;
    if (rst) begin
      q.delete();
      return;
    end
    acc = in_valid && (q.size() < DEPTH);
    deq = (q.size() != 0) && !stall;
    if (deq) void'(q.pop_front());
    if (acc) begin
      e.r = in_reg;
      e.d = in_data;
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rg, input logic [WIDTH-1:0] d,
                       input logic st, input logic [2:0] r1, input logic [2:0] r2);
    in_valid = v;
    in_reg   = rg;
    in_data  = d;
    stall    = st;
    rreg1    = r1;
    rreg2    = r2;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd0);
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 3; i++) tick();

    // Single result, no stall.
    drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd3, 3'd0);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd3, 3'd0);
    tick();
    tick();

    // Fill under stall. The fifth result is refused, then the buffer drains in order.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'(i), 16'(i * 16'h0011), 1'b1, 3'd1, 3'd4);
      tick();
    end
    drive(1'b0, 3'd0, '0, 1'b0, 3'd2, 3'd5);
    for (int i = 0; i < 5; i++) tick();

    // Two writes to the same register under stall. Forwarding must pick the younger one.
    drive(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 3'd5);
    tick();
    drive(1'b1, 3'd2, 16'hBBBB, 1'b1, 3'd2, 3'd5);
    tick();
    drive(1'b0, 3'd0, '0, 1'b1, 3'd2, 3'd5);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd2, 3'd5);
    for (int i = 0; i < 3; i++) tick();

    // Register 0 is treated as an ordinary register.
    drive(1'b1, 3'd0, 16'h0F0F, 1'b1, 3'd0, 3'd0);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd7);
    tick();
    tick();

    // Simultaneous enqueue and dequeue at count 2, followed by reset in the middle of the drain.
    drive(1'b1, 3'd6, 16'h6001, 1'b1, 3'd6, 3'd7);
    tick();
    drive(1'b1, 3'd7, 16'h7002, 1'b1, 3'd6, 3'd7);
    tick();
    drive(1'b1, 3'd6, 16'h6003, 1'b0, 3'd6, 3'd7);
    tick();
    drive(1'b1, 3'd1, 16'h1004, 1'b0, 3'd6, 3'd1);
    tick();
    rst = 1'b1;
    q.delete();
    #1;
    check_outputs();
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd6, 3'd1);
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Randomized traffic, including an occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            16'($urandom),
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
